// File: rtl/alu_resp_unit.sv
// Valid/ready ALU responder: computes invert/add/sub/double on accept and queues
// result+flags in a DEPTH-entry response FIFO; out_valid rises one cycle after accept.
module alu_resp_unit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic [CNT_W-1:0] resp_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    logic             z;
  } resp_t;

  resp_t             mem_q [DEPTH];
  resp_t             mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  resp_count_q, resp_count_d;

  resp_t            new_resp;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, so a full FIFO refuses a push even while popping.
  assign in_ready  = (count_q < CNT_FW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    sum      = {1'b0, in_a} + {1'b0, in_b};
    diff     = {1'b0, in_a} - {1'b0, in_b};
    new_resp = '0;
    case (in_s)
      2'b00: new_resp.y = ~in_a;
      2'b01: begin
        new_resp.y = sum[WIDTH-1:0];
        new_resp.c = sum[WIDTH];
        new_resp.v = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      2'b10: begin
        // Top bit of the widened difference is the unsigned borrow (A < B).
        new_resp.y = diff[WIDTH-1:0];
        new_resp.c = diff[WIDTH];
        new_resp.v = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      default: begin
        new_resp.y = {in_a[WIDTH-2:0], 1'b0};
        new_resp.c = in_a[WIDTH-1];
        new_resp.v = in_a[WIDTH-1] ^ in_a[WIDTH-2];
      end
    endcase
    new_resp.z = (new_resp.y == '0);
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    resp_count_d = resp_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_resp;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      resp_count_d = resp_count_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_count_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_count_q <= resp_count_d;
    end
  end

  // Storage is cleared on reset, so the head reads as zero until the first push.
  assign out_y      = mem_q[rd_ptr_q].y;
  assign out_c      = mem_q[rd_ptr_q].c;
  assign out_v      = mem_q[rd_ptr_q].v;
  assign out_z      = mem_q[rd_ptr_q].z;
  assign resp_count = resp_count_q;

endmodule
